// File: rtl/serial_subtractor_eight_bits_if.sv
// Handshake and operand bundle for the bit-serial 8-bit subtractor.
// The OVF signal exists only when SUB_OVF_EN is defined.
interface serial_subtractor_eight_bits_if;
   logic       start;
   logic [7:0] A;
   logic [7:0] B;
   logic       B0;
   logic [7:0] D;
   logic       Bout;
   logic       busy;
   logic       done;
`ifdef SUB_OVF_EN
   logic       OVF;

   modport master (output start, A, B, B0, input D, Bout, busy, done, OVF);
   modport slave  (input start, A, B, B0, output D, Bout, busy, done, OVF);
`else
   modport master (output start, A, B, B0, input D, Bout, busy, done);
   modport slave  (input start, A, B, B0, output D, Bout, busy, done);
`endif
endinterface

// File: rtl/serial_subtractor_eight_bits.sv
// Bit-serial 8-bit subtractor: D = A - B - B0, LSB first, one full-subtractor cell.
// Define SUB_OVF_EN to add the signed-overflow output OVF.
//
// state | meaning
// IDLE  | waiting for start, D/Bout hold last result
// SHIFT | processing bit cnt, busy=1
// DONE  | one-cycle done pulse, start may issue the next operation
module serial_subtractor_eight_bits (
   input logic clk,
   input logic rst_n,
   serial_subtractor_eight_bits_if.slave sub
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;

   logic [7:0] op_a;
   logic [7:0] op_b;
   logic       br;
   logic [7:0] res;
   logic [2:0] cnt;
   logic [7:0] d_q;
   logic       bout_q;

   logic       accept;
   logic       last_bit;
   logic       bit_a;
   logic       bit_b;
   logic       bit_d;
   logic       br_next;

   assign accept   = sub.start && ((state == IDLE) || (state == DONE));
   assign last_bit = (cnt == 3'd7);

   assign bit_a   = op_a[0];
   assign bit_b   = op_b[0];
   assign bit_d   = bit_a ^ bit_b ^ br;
   assign br_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sub.start) state_nxt = SHIFT;
         SHIFT:   if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = sub.start ? SHIFT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Result registers move only on the bit-7 cycle so D/Bout stay stable while busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a   <= 8'h00;
         op_b   <= 8'h00;
         br     <= 1'b0;
         res    <= 8'h00;
         cnt    <= 3'd0;
         d_q    <= 8'h00;
         bout_q <= 1'b0;
      end else if (accept) begin
         op_a <= sub.A;
         op_b <= sub.B;
         br   <= sub.B0;
         cnt  <= 3'd0;
      end else if (state == SHIFT) begin
         op_a <= {1'b0, op_a[7:1]};
         op_b <= {1'b0, op_b[7:1]};
         br   <= br_next;
         res  <= {bit_d, res[7:1]};
         cnt  <= cnt + 3'd1;
         if (last_bit) begin
            d_q    <= {bit_d, res[7:1]};
            bout_q <= br_next;
         end
      end
   end

`ifdef SUB_OVF_EN
   logic ovf_q;

   // On the bit-7 cycle br is the borrow into the sign bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (!accept && (state == SHIFT) && last_bit) begin
         ovf_q <= br ^ br_next;
      end
   end

   assign sub.OVF = ovf_q;
`endif

   assign sub.D    = d_q;
   assign sub.Bout = bout_q;
   assign sub.busy = (state == SHIFT);
   assign sub.done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor_eight_bits.sv
// Self-checking bench for serial_subtractor_eight_bits: directed cases, random
// operands and an exhaustive 4-bit sweep against an arithmetic reference model.
module tb_serial_subtractor_eight_bits;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   logic [7:0] exp_d;
   logic       exp_b;
   logic       exp_o;
   logic [7:0] last_d;
   logic       last_b;
   logic       last_o;

   serial_subtractor_eight_bits_if sif ();

   serial_subtractor_eight_bits dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sub   (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the operands.
   task automatic model(input logic [7:0] a, input logic [7:0] b, input logic b0);
      int diff;
      int sdiff;
      diff  = int'(a) - int'(b) - int'(b0);
      sdiff = int'($signed(a)) - int'($signed(b)) - int'(b0);
      exp_d = diff[7:0];
      exp_b = (int'(a) < int'(b) + int'(b0));
      exp_o = (sdiff > 127) || (sdiff < -128);
   endtask

   task automatic check_ovf(input string tag, input logic exp);
`ifdef SUB_OVF_EN
      check(tag, {31'd0, sif.OVF}, {31'd0, exp});
`endif
   endtask

   // Presents operands with start for one edge, then scrambles the inputs.
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic b0);
      sif.A     = a;
      sif.B     = b;
      sif.B0    = b0;
      sif.start = 1'b1;
      model(a, b, b0);
      @(posedge clk);
      #1;
      sif.start = 1'b0;
      sif.A     = 8'($urandom);
      sif.B     = 8'($urandom);
      sif.B0    = 1'($urandom);
   endtask

   // Walks the 8 busy cycles and the done cycle; optionally pokes start mid-shift.
   task automatic complete(input bit inject);
      for (int i = 0; i < 8; i++) begin
         check("busy_shift", {31'd0, sif.busy}, 32'd1);
         check("done_shift", {31'd0, sif.done}, 32'd0);
         check("d_hold", {24'd0, sif.D}, {24'd0, last_d});
         check("bout_hold", {31'd0, sif.Bout}, {31'd0, last_b});
         check_ovf("ovf_hold", last_o);
         if (inject && i == 3) begin
            sif.start = 1'b1;
            sif.A     = 8'd1;
            sif.B     = 8'd2;
            sif.B0    = 1'b0;
         end
         if (inject && i == 4) sif.start = 1'b0;
         @(posedge clk);
         #1;
      end
      check("done_pulse", {31'd0, sif.done}, 32'd1);
      check("busy_done", {31'd0, sif.busy}, 32'd0);
      check("d_result", {24'd0, sif.D}, {24'd0, exp_d});
      check("bout_result", {31'd0, sif.Bout}, {31'd0, exp_b});
      check_ovf("ovf_result", exp_o);
      last_d = exp_d;
      last_b = exp_b;
      last_o = exp_o;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
      check("done_drop", {31'd0, sif.done}, 32'd0);
      check("busy_idle", {31'd0, sif.busy}, 32'd0);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      last_d    = 8'h00;
      last_b    = 1'b0;
      last_o    = 1'b0;
      sif.start = 1'b0;
      sif.A     = 8'h00;
      sif.B     = 8'h00;
      sif.B0    = 1'b0;
      rst_n     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_d", {24'd0, sif.D}, 32'd0);
      check("rst_bout", {31'd0, sif.Bout}, 32'd0);
      check("rst_busy", {31'd0, sif.busy}, 32'd0);
      check("rst_done", {31'd0, sif.done}, 32'd0);
      check_ovf("rst_ovf", 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 200 - 55 = 145
      issue(8'd200, 8'd55, 1'b0);
      check("exp_d_200_55", {24'd0, exp_d}, 32'h91);
      complete(1'b0);
      idle_cycle();

      issue(8'h00, 8'h01, 1'b0);
      complete(1'b0);
      idle_cycle();
      issue(8'h10, 8'h10, 1'b1);
      complete(1'b0);
      idle_cycle();

      // start during SHIFT ignored, then start held across done chains another op
      issue(8'd9, 8'd4, 1'b0);
      complete(1'b1);
      check("ignored_d", {24'd0, sif.D}, 32'd5);
      issue(8'd1, 8'd2, 1'b0);
      complete(1'b0);
      idle_cycle();

      // reset mid-operation
      issue(8'hAA, 8'h0F, 1'b0);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      check("pre_rst_busy", {31'd0, sif.busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_d", {24'd0, sif.D}, 32'd0);
      check("midrst_bout", {31'd0, sif.Bout}, 32'd0);
      check("midrst_busy", {31'd0, sif.busy}, 32'd0);
      check("midrst_done", {31'd0, sif.done}, 32'd0);
      check_ovf("midrst_ovf", 1'b0);
      repeat (6) begin
         @(posedge clk);
         #1;
         check("midrst_nodone", {31'd0, sif.done}, 32'd0);
      end
      rst_n  = 1'b1;
      last_d = 8'h00;
      last_b = 1'b0;
      last_o = 1'b0;
      @(posedge clk);
      #1;
      issue(8'd3, 8'd3, 1'b0);
      complete(1'b0);
      idle_cycle();

      // signed overflow corner cases
      issue(8'h80, 8'h01, 1'b0);
      complete(1'b0);
      issue(8'h7F, 8'hFF, 1'b0);
      complete(1'b0);
      issue(8'h05, 8'h03, 1'b0);
      complete(1'b0);
      idle_cycle();

      for (int n = 0; n < 40; n++) begin
         issue(8'($urandom), 8'($urandom), 1'($urandom));
         complete(1'b0);
         if ($urandom_range(0, 1) == 0) idle_cycle();
      end

      // back-to-back exhaustive low-nibble sweep
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int c = 0; c < 2; c++) begin
               issue(8'(a), 8'(b), 1'(c));
               complete(1'b0);
            end
         end
      end
      idle_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
